rgb_lcd_driver: RTL and testbench
=================================

# rgb_lcd_driver

Timing generator and pixel sink for the 800×480 RGB565 LCD panel. Runs free on `lcd_clk` and produces HSYNC/VSYNC/DE and the panel data bus. Issues pixel coordinates one cycle ahead of DE so that a registered pixel source such as the character or graphics display generators has its `pixel_data` ready exactly in the DE cycle. Also sequences the backlight and reports frame boundaries to the rest of the design.

## Interface
Parameters:
- H_SYNC, 11'd128, HSYNC pulse width (clocks)
- H_BACK, 11'd88, horizontal back porch
- H_DISP, 11'd800, active pixels per line
- H_FRONT, 11'd40, horizontal front porch
- V_SYNC, 11'd2, VSYNC pulse width (lines)
- V_BACK, 11'd33, vertical back porch
- V_DISP, 11'd480, active lines
- V_FRONT, 11'd10, vertical front porch
- Derived: H_TOTAL = sum of H_* (1056); V_TOTAL = sum of V_* (525)

Ports:
- lcd_clk  in  1  pixel clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- pixel_data  in  16  RGB565 from pixel source, registered by source one cycle after coordinates
- pixel_xpos  out  11  requested pixel x (0..H_DISP-1)
- pixel_ypos  out  11  requested pixel y (0..V_DISP-1)
- lcd_hs  out  1  HSYNC, active-low
- lcd_vs  out  1  VSYNC, active-low
- lcd_de  out  1  data enable, active-high
- lcd_rgb  out  16  panel data bus
- lcd_bl  out  1  backlight enable
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0
- frame_cnt  out  8  completed-frame counter, wraps

Reset: sys_rst_n, asynchronous, active-low; clock lcd_clk.

## Operation
- h_cnt, 11 bits: 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt, 11 bits: 0..V_TOTAL-1, wraps to 0 when both counters are at their maxima.
- lcd_hs = 0 iff h_cnt < H_SYNC. lcd_vs = 0 iff v_cnt < V_SYNC. Decoding is combinational from the registered counters.
- Active region: h_cnt ∈ [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt ∈ [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP). lcd_de = 1 exactly in this region.
- data_req (internal): the same window shifted one clock earlier horizontally, i.e. h_cnt ∈ [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_DISP-1), with the same vertical window.
- Coordinates:
  - When data_req=1: pixel_xpos = h_cnt-(H_SYNC+H_BACK-1) and pixel_ypos = v_cnt-(V_SYNC+V_BACK).
  - When data_req=0: both are 0.
- lcd_rgb = lcd_de ? pixel_data : 16'h0000. Blanking is always black.
- frame_start is 1 in the single cycle where h_cnt=0 and v_cnt=0.
- Frame counting: frame_cnt increments on the clock edge where v_cnt wraps V_TOTAL-1→0 at h_cnt=H_TOTAL-1. It wraps 255→0.
- Backlight sequencing uses a two-state FSM:
  - BL_OFF → BL_ON on the first frame_cnt increment after reset.
  - BL_ON is held until reset.
  - lcd_bl = 1 in BL_ON, so one full blank/garbage frame is hidden.

## Timing
- Reset values: h_cnt=0, v_cnt=0, frame_cnt=0, FSM=BL_OFF. While sys_rst_n=0, the outputs are forced to lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_rgb=0, pixel_xpos=0, pixel_ypos=0, frame_start=0, lcd_bl=0.
- First cycle after reset release: h_cnt=0, v_cnt=0, frame_start=1, lcd_hs=0, lcd_vs=0.
- Coordinate-to-data latency is one clock. Coordinate (x,y) appears in cycle N; lcd_de=1 and lcd_rgb must carry that pixel in cycle N+1. The source must register exactly once.
- Line = 1056 clocks; frame = 554400 clocks. First DE of a frame: h_cnt=216, v_cnt=35. Last DE: h_cnt=1015, v_cnt=514.
- Last data_req of a line is at h_cnt=1014 (x=799). At h_cnt=1015, pixel_xpos returns to 0.
- Mid-frame reset: all counters clear asynchronously and lcd_bl drops immediately. Restart is from frame_start with the FSM in BL_OFF.
- Non-default parameters must keep every sum below 2048. Comparisons are 11-bit unsigned.

## Test plan
- Reset, release, run 2 frames → frame_start pulses at cycle 0 and 554400; frame_cnt = 2; lcd_bl rises the cycle after frame_cnt reaches 1.
- Line timing: count lcd_hs low-width → 128 clocks; period 1056; lcd_vs low for 2×1056 clocks, period 554400.
- DE window: on line v_cnt=35, lcd_de rises at h_cnt=216 and falls after 800 clocks. Zero DE on v_cnt 0..34 and 515..524. Total DE count per frame = 384000.
- Alignment: the source model registers pixel_data = {pixel_xpos[4:0], pixel_ypos[5:0], pixel_xpos[9:5]} → every lcd_rgb during DE decodes back to the correct (x,y). First pixel x=0,y=0; last pixel x=799,y=479.
- Blanking: drive pixel_data=16'hFFFF constantly → lcd_rgb=0 whenever lcd_de=0.
- Assert sys_rst_n low mid-line at v_cnt=200, h_cnt=500 → all outputs at their reset values within the same cycle. After release, timing restarts from cycle 0, lcd_bl stays 0 for one full frame.

Source files
------------

// File: rtl/rgb_lcd_driver.sv
// Timing generator and pixel sink for an RGB565 LCD panel.
// Requests pixel coordinates one clock ahead of DE so a registered source lines up with DE.
module rgb_lcd_driver #(
    parameter logic [10:0] H_SYNC  = 11'd128,
    parameter logic [10:0] H_BACK  = 11'd88,
    parameter logic [10:0] H_DISP  = 11'd800,
    parameter logic [10:0] H_FRONT = 11'd40,
    parameter logic [10:0] V_SYNC  = 11'd2,
    parameter logic [10:0] V_BACK  = 11'd33,
    parameter logic [10:0] V_DISP  = 11'd480,
    parameter logic [10:0] V_FRONT = 11'd10
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [15:0] lcd_rgb,
    output logic        lcd_bl,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam logic [10:0] H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [10:0] V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam logic [10:0] H_MAX       = H_TOTAL - 11'd1;
    localparam logic [10:0] V_MAX       = V_TOTAL - 11'd1;
    localparam logic [10:0] H_ACT_START = H_SYNC + H_BACK;
    localparam logic [10:0] H_ACT_END   = H_SYNC + H_BACK + H_DISP;
    localparam logic [10:0] H_REQ_START = H_ACT_START - 11'd1;
    localparam logic [10:0] H_REQ_END   = H_ACT_END - 11'd1;
    localparam logic [10:0] V_ACT_START = V_SYNC + V_BACK;
    localparam logic [10:0] V_ACT_END   = V_SYNC + V_BACK + V_DISP;

    typedef enum logic {BL_OFF = 1'b0, BL_ON = 1'b1} bl_state_t;

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        frame_wrap;
    logic        frame_wrap_d;
    logic        h_act;
    logic        h_req;
    logic        v_act;
    logic        data_req;
    bl_state_t   bl_state;

    assign frame_wrap = (h_cnt == H_MAX) && (v_cnt == V_MAX);

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= 11'd0;
            v_cnt <= 11'd0;
        end else if (h_cnt == H_MAX) begin
            h_cnt <= 11'd0;
            v_cnt <= (v_cnt == V_MAX) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt    <= 8'd0;
            frame_wrap_d <= 1'b0;
        end else begin
            frame_wrap_d <= frame_wrap;
            if (frame_wrap)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Backlight stays dark until the first frame has been fully scanned out,
    // so whatever the panel shows before a clean frame is never visible.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bl_state <= BL_OFF;
            lcd_bl   <= 1'b0;
        end else begin
            case (bl_state)
                BL_OFF: begin
                    if (frame_wrap_d) begin
                        bl_state <= BL_ON;
                        lcd_bl   <= 1'b1;
                    end
                end
                BL_ON: begin
                    bl_state <= BL_ON;
                    lcd_bl   <= 1'b1;
                end
                default: begin
                    bl_state <= BL_OFF;
                    lcd_bl   <= 1'b0;
                end
            endcase
        end
    end

    assign h_act    = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
    assign h_req    = (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END);
    assign v_act    = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    assign data_req = sys_rst_n && h_req && v_act;

    // Outputs are gated by reset so they take their idle values asynchronously.
    assign lcd_hs      = !(sys_rst_n && (h_cnt < H_SYNC));
    assign lcd_vs      = !(sys_rst_n && (v_cnt < V_SYNC));
    assign lcd_de      = sys_rst_n && h_act && v_act;
    assign lcd_rgb     = lcd_de ? pixel_data : 16'h0000;
    assign frame_start = sys_rst_n && (h_cnt == 11'd0) && (v_cnt == 11'd0);
    assign pixel_xpos  = data_req ? (h_cnt - H_REQ_START) : 11'd0;
    assign pixel_ypos  = data_req ? (v_cnt - V_ACT_START) : 11'd0;

endmodule

// File: tb/tb_rgb_lcd_driver.sv
// Directed bench: a small-parameter instance for whole-frame behaviour and a
// default-parameter instance for the real 800x480 line/frame landmarks.
module tb_rgb_lcd_driver;

    logic        lcd_clk;
    logic        rst_n;
    logic        rst_big_n;
    logic        use_ffff;

    logic [15:0] pix_s, pixel_data_s;
    logic [10:0] xpos_s, ypos_s;
    logic        hs_s, vs_s, de_s, bl_s, fs_s;
    logic [15:0] rgb_s;
    logic [7:0]  fc_s;

    logic [15:0] pix_b, pixel_data_b;
    logic [10:0] xpos_b, ypos_b;
    logic        hs_b, vs_b, de_b, bl_b, fs_b;
    logic [15:0] rgb_b;
    logic [7:0]  fc_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int big_edges = 0;
    int h, v, de_cnt, bad_de, bad_rgb;
    logic        de_exp;
    logic [10:0] ex, ey;

    // Small geometry: H 4+3+8+2 = 17, V 2+2+4+1 = 9, frame = 153 clocks.
    rgb_lcd_driver #(
        .H_SYNC(11'd4), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2),
        .V_SYNC(11'd2), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1)
    ) u_small (
        .lcd_clk(lcd_clk), .sys_rst_n(rst_n), .pixel_data(pixel_data_s),
        .pixel_xpos(xpos_s), .pixel_ypos(ypos_s), .lcd_hs(hs_s), .lcd_vs(vs_s),
        .lcd_de(de_s), .lcd_rgb(rgb_s), .lcd_bl(bl_s), .frame_start(fs_s),
        .frame_cnt(fc_s)
    );

    rgb_lcd_driver u_big (
        .lcd_clk(lcd_clk), .sys_rst_n(rst_big_n), .pixel_data(pixel_data_b),
        .pixel_xpos(xpos_b), .pixel_ypos(ypos_b), .lcd_hs(hs_b), .lcd_vs(vs_b),
        .lcd_de(de_b), .lcd_rgb(rgb_b), .lcd_bl(bl_b), .frame_start(fs_b),
        .frame_cnt(fc_b)
    );

    // Clock and the registered pixel sources.
    initial lcd_clk = 1'b0;
    always #5 lcd_clk = ~lcd_clk;

    always @(posedge lcd_clk) begin
        pix_s <= {xpos_s[4:0], ypos_s[5:0], xpos_s[9:5]};
        pix_b <= {xpos_b[4:0], ypos_b[5:0], xpos_b[9:5]};
        if (rst_big_n)
            big_edges <= big_edges + 1;
    end

    assign pixel_data_s = use_ffff ? 16'hFFFF : pix_s;
    assign pixel_data_b = use_ffff ? 16'hFFFF : pix_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge lcd_clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) next_cycle();
    endtask

    task automatic goto_big(input int n);
        while (big_edges < n) begin
            @(negedge lcd_clk);
            #1;
        end
    endtask

    task automatic release_small();
        @(negedge lcd_clk);
        rst_n = 1'b1;
        #1;
        cyc = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        rst_big_n = 1'b0;
        use_ffff  = 1'b1;
        repeat (3) @(negedge lcd_clk);
        #1;
        chk("rst_hs", 32'(hs_s), 32'd1);
        chk("rst_vs", 32'(vs_s), 32'd1);
        chk("rst_de", 32'(de_s), 32'd0);
        chk("rst_rgb", 32'(rgb_s), 32'd0);
        chk("rst_fs", 32'(fs_s), 32'd0);
        chk("rst_bl", 32'(bl_s), 32'd0);
        chk("rst_fc", 32'(fc_s), 32'd0);
        chk("rst_xy", {5'd0, xpos_s, 5'd0, ypos_s}, 32'd0);
        use_ffff = 1'b0;

        // Frame 0: sync landmarks.
        release_small();
        chk("c0_fs", 32'(fs_s), 32'd1);
        chk("c0_hs", 32'(hs_s), 32'd0);
        chk("c0_vs", 32'(vs_s), 32'd0);
        goto(1);  chk("c1_fs", 32'(fs_s), 32'd0);
        goto(3);  chk("c3_hs", 32'(hs_s), 32'd0);
        goto(4);  chk("c4_hs", 32'(hs_s), 32'd1);
        goto(16); chk("c16_hs", 32'(hs_s), 32'd1);
        goto(17); chk("c17_hs", 32'(hs_s), 32'd0);
        chk("c17_fs", 32'(fs_s), 32'd0);
        goto(33); chk("c33_vs", 32'(vs_s), 32'd0);
        goto(34); chk("c34_vs", 32'(vs_s), 32'd1);

        // Rest of frame 0: DE window and pixel alignment against cycle-derived (x,y).
        de_cnt = 0; bad_de = 0; bad_rgb = 0;
        while (cyc < 152) begin
            next_cycle();
            h = cyc % 17;
            v = (cyc / 17) % 9;
            de_exp = (h >= 7 && h < 15 && v >= 4 && v < 8);
            if (de_s !== de_exp) bad_de++;
            if (de_s === 1'b1) begin
                de_cnt++;
                ex = 11'(h - 7);
                ey = 11'(v - 4);
                if (rgb_s !== {ex[4:0], ey[5:0], ex[9:5]}) bad_rgb++;
            end
        end
        chk("f0_de_window", 32'(bad_de), 32'd0);
        chk("f0_rgb_align", 32'(bad_rgb), 32'd0);
        chk("f0_de_count", 32'(de_cnt), 32'd32);
        chk("c152_fc", 32'(fc_s), 32'd0);
        chk("c152_bl", 32'(bl_s), 32'd0);

        // Frame 1: counter/backlight and directed DE edges.
        goto(153); chk("c153_fs", 32'(fs_s), 32'd1);
        chk("c153_fc", 32'(fc_s), 32'd1);
        chk("c153_bl", 32'(bl_s), 32'd0);
        goto(154); chk("c154_bl", 32'(bl_s), 32'd1);
        goto(214); chk("l3_de", 32'(de_s), 32'd0);
        chk("l3_hs", 32'(hs_s), 32'd1);
        goto(227); chk("pre_de", 32'(de_s), 32'd0);
        chk("req_x0", {5'd0, xpos_s, 5'd0, ypos_s}, 32'd0);
        goto(228); chk("de_rise", 32'(de_s), 32'd1);
        chk("x1", 32'(xpos_s), 32'd1);
        chk("rgb_x0y0", 32'(rgb_s), 32'h0000);
        goto(229); chk("rgb_x1y0", 32'(rgb_s), 32'h0800);
        chk("x2", 32'(xpos_s), 32'd2);
        goto(234); chk("x7_last_req", 32'(xpos_s), 32'd7);
        goto(235); chk("de_last", 32'(de_s), 32'd1);
        chk("rgb_x7y0", 32'(rgb_s), 32'h3800);
        chk("x_back_0", 32'(xpos_s), 32'd0);
        goto(236); chk("de_fall", 32'(de_s), 32'd0);
        chk("rgb_blank", 32'(rgb_s), 32'd0);
        goto(246); chk("rgb_x1y1", 32'(rgb_s), 32'h0820);
        chk("y1", 32'(ypos_s), 32'd1);
        goto(286); chk("rgb_x7y3", 32'(rgb_s), 32'h3860);
        goto(299); chk("vfp_de", 32'(de_s), 32'd0);

        // Frame 2: constant white source must be black whenever DE is low.
        goto(305);
        use_ffff = 1'b1;
        goto(306); chk("c306_fc", 32'(fc_s), 32'd2);
        chk("c306_fs", 32'(fs_s), 32'd1);
        de_cnt = 0; bad_rgb = 0;
        while (cyc < 400) begin
            next_cycle();
            if (de_s === 1'b1) begin
                de_cnt++;
                if (rgb_s !== 16'hFFFF) bad_rgb++;
            end else if (rgb_s !== 16'h0000) begin
                bad_rgb++;
            end
        end
        chk("blank_rgb", 32'(bad_rgb), 32'd0);
        chk("blank_de_count", 32'(de_cnt), 32'd11);

        // Mid-line reset inside the active area.
        goto(401); chk("pre_rst_de", 32'(de_s), 32'd1);
        chk("pre_rst_bl", 32'(bl_s), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hs", 32'(hs_s), 32'd1);
        chk("mid_rst_vs", 32'(vs_s), 32'd1);
        chk("mid_rst_de", 32'(de_s), 32'd0);
        chk("mid_rst_rgb", 32'(rgb_s), 32'd0);
        chk("mid_rst_bl", 32'(bl_s), 32'd0);
        chk("mid_rst_fc", 32'(fc_s), 32'd0);
        chk("mid_rst_xy", {5'd0, xpos_s, 5'd0, ypos_s}, 32'd0);
        use_ffff = 1'b0;
        repeat (3) @(negedge lcd_clk);
        release_small();
        chk("re_c0_fs", 32'(fs_s), 32'd1);
        chk("re_c0_bl", 32'(bl_s), 32'd0);
        goto(152); chk("re_c152_bl", 32'(bl_s), 32'd0);
        goto(153); chk("re_c153_fc", 32'(fc_s), 32'd1);
        chk("re_c153_bl", 32'(bl_s), 32'd0);
        goto(154); chk("re_c154_bl", 32'(bl_s), 32'd1);

        // Default 800x480 geometry.
        chk("big_rst_hs", 32'(hs_b), 32'd1);
        chk("big_rst_fs", 32'(fs_b), 32'd0);
        @(negedge lcd_clk);
        rst_big_n = 1'b1;
        #1;
        chk("big_c0_fs", 32'(fs_b), 32'd1);
        chk("big_c0_hsvs", {hs_b, vs_b}, 32'd0);
        goto_big(127);   chk("big_hs_127", 32'(hs_b), 32'd0);
        goto_big(128);   chk("big_hs_128", 32'(hs_b), 32'd1);
        goto_big(1055);  chk("big_hs_1055", 32'(hs_b), 32'd1);
        goto_big(1056);  chk("big_hs_1056", 32'(hs_b), 32'd0);
        chk("big_fs_1056", 32'(fs_b), 32'd0);
        goto_big(2111);  chk("big_vs_2111", 32'(vs_b), 32'd0);
        goto_big(2112);  chk("big_vs_2112", 32'(vs_b), 32'd1);
        goto_big(37175); chk("big_pre_de", 32'(de_b), 32'd0);
        chk("big_req_xy", {5'd0, xpos_b, 5'd0, ypos_b}, 32'd0);
        goto_big(37176); chk("big_de_rise", 32'(de_b), 32'd1);
        chk("big_x1", 32'(xpos_b), 32'd1);
        goto_big(37177); chk("big_rgb_x1", 32'(rgb_b), 32'h0800);
        goto_big(37974); chk("big_x799", 32'(xpos_b), 32'd799);
        goto_big(37975); chk("big_de_last", 32'(de_b), 32'd1);
        chk("big_rgb_x799", 32'(rgb_b), 32'hF818);
        chk("big_x_back_0", 32'(xpos_b), 32'd0);
        goto_big(37976); chk("big_de_fall", 32'(de_b), 32'd0);
        chk("big_rgb_blank", 32'(rgb_b), 32'd0);
        chk("big_bl", 32'(bl_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
